// File: rtl/binary_map_writer_pkg.sv
// Shared types and helpers for the binary similarity map writer.
// Latency: n/a (types, constants and a pure address function).
// Backpressure: n/a.
package binary_map_writer_pkg;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One SRAM word holds this many map bits.
    localparam int WORD_W    = 16;
    localparam int WORD_LOG2 = 4;

    // Word w of row token t (1-based) lives at w*dimen + (t-1).
    // The reader walks the same layout: base t-1, stride dimen.
    function automatic logic [31:0] map_addr(input logic [31:0] word,
                                             input logic [31:0] row,
                                             input logic [31:0] dim);
        return word * dim + row - 32'd1;
    endfunction

endpackage

// File: rtl/binary_map_writer_if.sv
// Score stream in, binary-map SRAM write port out.
// Latency: n/a (signal bundle only).
// Backpressure: sim_valid/sim_ready handshake on the score stream; SRAM side never stalls.
interface binary_map_writer_if #(
    parameter int binary_width = 16
);
    logic [31:0]           sim;
    logic                  sim_valid;
    logic                  sim_ready;
    logic [binary_width:0] binary_addr;
    logic                  binary_cen;
    logic                  binary_wen;
    logic                  binary_ren;
    logic [15:0]           binary_wdata;

    // The map writer: consumes scores, drives the SRAM port.
    modport master (
        input  sim, sim_valid,
        output sim_ready,
        output binary_addr, binary_cen, binary_wen, binary_ren, binary_wdata
    );

    // The environment: produces scores, observes the SRAM port.
    modport slave (
        output sim, sim_valid,
        input  sim_ready,
        input  binary_addr, binary_cen, binary_wen, binary_ren, binary_wdata
    );
endinterface

// File: rtl/binary_map_packer.sv
// Serial-in accumulator: collects one bit per accept into a 16-bit word, LSB first.
// Latency: completed word is presented combinationally with the 16th bit (word_done).
// Backpressure: none; bits are taken whenever bit_vld is high, clr restarts a word.
module binary_map_packer
    import binary_map_writer_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clr,
    input  logic              bit_vld,
    input  logic              bit_dat,
    output logic              word_done,
    output logic [WORD_W-1:0] word_dat
);

    logic [WORD_W-1:0]    pack_q;
    logic [WORD_W-1:0]    pack_nxt;
    logic [WORD_LOG2-1:0] cnt_q;

    // Current word with the incoming bit dropped into its slot.
    always_comb begin
        pack_nxt        = pack_q;
        pack_nxt[cnt_q] = bit_dat;
        word_dat        = pack_nxt;
        word_done       = bit_vld && (cnt_q == WORD_LOG2'(WORD_W - 1));
    end

    // Bit slot counter and partial word; a finished word starts the next from zero.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else if (bit_vld) begin
            pack_q <= word_done ? '0 : pack_nxt;
            cnt_q  <= cnt_q + WORD_LOG2'(1);
        end
    end

endmodule

// File: rtl/binary_map_writer.sv
// Thresholds a raster stream of similarity scores into the binary map SRAM (optional BINARY_MAP_ROWCOUNT_EN adds per-row 1-bit counts).
// Latency: write strobe 1 cycle after a word's 16th score; write_finish 2 cycles after the last score.
// Backpressure: sim_ready follows EN in FILL; SRAM writes never stall and complete even if EN drops.
module binary_map_writer
    import binary_map_writer_pkg::*;
#(
    parameter int dimen        = 1024,
    parameter int binary_width = 16,
    parameter int index_width  = 10
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   EN,
    input  logic                   START,
    input  logic [31:0]            threshold,
    binary_map_writer_if.master    bus,
    output logic                   write_finish,
    output logic                   busy
`ifdef BINARY_MAP_ROWCOUNT_EN
    ,
    output logic [index_width:0]   row_count,
    output logic                   row_count_valid
`endif
);

    localparam int CNT_W  = index_width + 1;
    localparam int ADDR_W = binary_width + 1;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   row_q;
    logic [CNT_W-1:0]   col_q;
    logic [31:0]        thr_q;

    logic               start_acc;
    logic               accept;
    logic               sim_ready_c;
    logic               col_last;
    logic               row_last;
    logic               sim_bit;

    logic               word_done;
    logic [WORD_W-1:0]  word_dat;

    logic [ADDR_W-1:0]  addr_q;
    logic               cen_q;
    logic               wen_q;
    logic [WORD_W-1:0]  wdata_q;

    assign col_last = (col_q == CNT_W'(dimen - 1));
    assign row_last = (row_q == CNT_W'(dimen));

    // Diagonal (column t-1 of row t) is a token compared with itself and is always 0.
    assign sim_bit = (bus.sim >= thr_q) && (col_q != (row_q - CNT_W'(1)));

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake decode. FLUSH/DONE advance unconditionally so the
    // last write and the finish pulse are never held hostage by EN.
    always_comb begin
        state_d     = state_q;
        start_acc   = 1'b0;
        accept      = 1'b0;
        sim_ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EN && START) begin
                    start_acc = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                sim_ready_c = EN;
                accept      = EN && bus.sim_valid;
                if (accept && col_last && row_last) state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Raster position and frame threshold; threshold is frozen for the whole frame.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            row_q <= CNT_W'(1);
            col_q <= '0;
            thr_q <= '0;
        end else if (start_acc) begin
            row_q <= CNT_W'(1);
            col_q <= '0;
            thr_q <= threshold;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_q + CNT_W'(1);
            end else begin
                col_q <= col_q + CNT_W'(1);
            end
        end
    end

    binary_map_packer u_packer (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr       (start_acc),
        .bit_vld   (accept),
        .bit_dat   (sim_bit),
        .word_done (word_done),
        .word_dat  (word_dat)
    );

    // Registered SRAM write: one-cycle strobe per completed word, back-to-back capable.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q  <= '0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            wdata_q <= '0;
        end else begin
            cen_q <= ~word_done;
            wen_q <= ~word_done;
            if (word_done) begin
                addr_q  <= ADDR_W'(map_addr(32'(col_q >> WORD_LOG2), 32'(row_q), 32'(dimen)));
                wdata_q <= word_dat;
            end
        end
    end

`ifdef BINARY_MAP_ROWCOUNT_EN
    logic [CNT_W-1:0] ones_q;

    // Running 1-bit count of the current row; published with the row's last word.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ones_q          <= '0;
            row_count       <= '0;
            row_count_valid <= 1'b0;
        end else if (start_acc) begin
            ones_q          <= '0;
            row_count_valid <= 1'b0;
        end else begin
            row_count_valid <= 1'b0;
            if (accept) begin
                if (col_last) begin
                    row_count       <= ones_q + CNT_W'(sim_bit);
                    row_count_valid <= 1'b1;
                    ones_q          <= '0;
                end else begin
                    ones_q <= ones_q + CNT_W'(sim_bit);
                end
            end
        end
    end
`endif

    assign bus.sim_ready    = sim_ready_c;
    assign bus.binary_addr  = addr_q;
    assign bus.binary_cen   = cen_q;
    assign bus.binary_wen   = wen_q;
    assign bus.binary_ren   = 1'b0;
    assign bus.binary_wdata = wdata_q;
    assign write_finish     = (state_q == ST_DONE);
    assign busy             = (state_q == ST_FILL) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_binary_map_writer.sv
// Randomized bench for binary_map_writer against a frame-level map model (dimen=32).
// Latency: checks write strobes 1 cycle after each 16th accept, finish 2 cycles after the last.
// Backpressure: EN and sim_valid toggled randomly; the map must match the unstalled result.
module tb_binary_map_writer;

    localparam int DIM = 32;
    localparam int BW  = 9;
    localparam int IW  = 5;
    localparam int NWR = DIM * DIM / 16;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        EN = 1'b0;
    logic        START = 1'b0;
    logic [31:0] threshold = '0;
    logic        write_finish;
    logic        busy;
`ifdef BINARY_MAP_ROWCOUNT_EN
    logic [IW:0] row_count;
    logic        row_count_valid;
`endif

    binary_map_writer_if #(.binary_width(BW)) bus ();

    binary_map_writer #(.dimen(DIM), .binary_width(BW), .index_width(IW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .EN           (EN),
        .START        (START),
        .threshold    (threshold),
        .bus          (bus),
        .write_finish (write_finish),
        .busy         (busy)
`ifdef BINARY_MAP_ROWCOUNT_EN
        ,
        .row_count       (row_count),
        .row_count_valid (row_count_valid)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] scores [1:DIM][0:DIM-1];
    logic [31:0] w_addr [$];
    logic [15:0] w_data [$];
    int          w_cyc  [$];
    int          exp_wcyc [$];
    int          rc_q   [$];
    int          fin_cnt = 0;
    int          fin_cyc = 0;
    int          ctl_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // SRAM port observer.
    always @(negedge CLK) begin
        if (RESET) begin
            if (bus.binary_cen !== bus.binary_wen) ctl_bad++;
            if (bus.binary_ren !== 1'b0) ctl_bad++;
            if (bus.binary_cen === 1'b0 && bus.binary_wen === 1'b0) begin
                w_addr.push_back(32'(bus.binary_addr));
                w_data.push_back(bus.binary_wdata);
                w_cyc.push_back(cyc);
            end
            if (write_finish === 1'b1) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
`ifdef BINARY_MAP_ROWCOUNT_EN
            if (row_count_valid === 1'b1) begin
                rc_q.push_back(int'(row_count));
                if (bus.binary_cen !== 1'b0) ctl_bad++;
            end
`endif
        end
    end

    // mode 0: constant 5, 1: constant 0, 2: odd columns 100 else 10, 3: random.
    task automatic fill_scores(input int mode);
        for (int t = 1; t <= DIM; t++)
            for (int j = 0; j < DIM; j++)
                case (mode)
                    0: scores[t][j] = 32'd5;
                    1: scores[t][j] = 32'd0;
                    2: scores[t][j] = (j % 2 == 1) ? 32'd100 : 32'd10;
                    default: scores[t][j] = $urandom_range(0, 1000);
                endcase
    endtask

    function automatic logic [15:0] model_word(input int t, input int w, input logic [31:0] thr);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            int j;
            j = w * 16 + b;
            r[b] = (scores[t][j] >= thr) && (j != t - 1);
        end
        return r;
    endfunction

    // Runs one frame; abort_at >= 0 pulls reset after that many accepted scores.
    task automatic run_frame(input logic [31:0] thr, input bit bp, input int abort_at);
        int idx, budget, last_c, fin_before;
        bit fire;
        w_addr.delete(); w_data.delete(); w_cyc.delete(); exp_wcyc.delete(); rc_q.delete();
        ctl_bad = 0;
        @(negedge CLK);
        EN = 1'b1; START = 1'b1; threshold = thr;
        @(negedge CLK);
        START = 1'b0;
        threshold = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        idx = 0; budget = 0; last_c = 0;
        while (idx < DIM * DIM && budget < 20000) begin
            if (idx == abort_at) begin
                fin_before = fin_cnt;
                RESET = 1'b0; EN = 1'b0; bus.sim_valid = 1'b0;
                #1;
                chk("rst_sim_ready", {31'd0, bus.sim_ready}, 32'd0);
                chk("rst_addr", 32'(bus.binary_addr), 32'd0);
                chk("rst_cen", {31'd0, bus.binary_cen}, 32'd1);
                chk("rst_wen", {31'd0, bus.binary_wen}, 32'd1);
                chk("rst_ren", {31'd0, bus.binary_ren}, 32'd0);
                chk("rst_wdata", 32'(bus.binary_wdata), 32'd0);
                chk("rst_finish", {31'd0, write_finish}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                repeat (3) @(negedge CLK);
                RESET = 1'b1;
                repeat (4) @(negedge CLK);
                chk("rst_no_finish", 32'(fin_cnt), 32'(fin_before));
                chk("rst_idle_busy", {31'd0, busy}, 32'd0);
                return;
            end
            EN            = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.sim_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.sim       = bus.sim_valid ? scores[idx / DIM + 1][idx % DIM] : $urandom;
            START         = bp && ($urandom_range(0, 15) == 0);
            #1;
            chk("sim_ready_eq_en", {31'd0, bus.sim_ready}, {31'd0, EN});
            fire = bus.sim_valid && EN;
            if (fire) begin
                if ((idx % DIM) % 16 == 15) exp_wcyc.push_back(cyc + 1);
                last_c = cyc;
                idx++;
            end
            @(negedge CLK);
            budget++;
        end
        if (budget >= 20000) chk("stream_budget", 32'(idx), 32'(DIM * DIM));
        // Final word must still be written with EN low.
        EN = 1'b0; bus.sim_valid = 1'b0; START = 1'b0;
        budget = 0;
        while (fin_cyc <= last_c && budget < 10) begin
            @(negedge CLK);
            budget++;
        end
        chk("finish_latency", 32'(fin_cyc - last_c), 32'd2);
        @(negedge CLK);
        chk("busy_after_finish", {31'd0, busy}, 32'd0);
        chk("finish_one_cycle", {31'd0, write_finish}, 32'd0);
        chk("ctl_strobe_errors", 32'(ctl_bad), 32'd0);
        chk("write_count", 32'(w_addr.size()), 32'(NWR));
        if (w_addr.size() == NWR && exp_wcyc.size() == NWR) begin
            for (int t = 1; t <= DIM; t++)
                for (int w = 0; w < DIM / 16; w++) begin
                    int k;
                    k = (t - 1) * (DIM / 16) + w;
                    chk("wr_addr", w_addr[k], 32'(w * DIM + t - 1));
                    chk("wr_data", 32'(w_data[k]), 32'(model_word(t, w, thr)));
                    chk("wr_cycle", 32'(w_cyc[k]), 32'(exp_wcyc[k]));
                end
        end
`ifdef BINARY_MAP_ROWCOUNT_EN
        chk("row_count_pulses", 32'(rc_q.size()), 32'(DIM));
        if (rc_q.size() == DIM)
            for (int t = 1; t <= DIM; t++) begin
                int ones;
                ones = 0;
                for (int j = 0; j < DIM; j++)
                    if (scores[t][j] >= thr && j != t - 1) ones++;
                chk("row_count", 32'(rc_q[t - 1]), 32'(ones));
            end
`endif
    endtask

    initial begin
        bus.sim = '0;
        bus.sim_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_sim_ready", {31'd0, bus.sim_ready}, 32'd0);
        chk("reset_cen", {31'd0, bus.binary_cen}, 32'd1);
        chk("reset_wen", {31'd0, bus.binary_wen}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_wdata", 32'(bus.binary_wdata), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // All ones: only the diagonal clears.
        fill_scores(0);
        run_frame(32'd0, 1'b0, -1);
        if (w_data.size() == NWR) begin
            chk("ones_row1_w0", 32'(w_data[0]), 32'h0000_FFFE);
            chk("ones_row17_w1", 32'(w_data[33]), 32'h0000_FFFE);
            chk("ones_row17_w0", 32'(w_data[32]), 32'h0000_FFFF);
        end

        // All zero.
        fill_scores(1);
        run_frame(32'hFFFF_FFFF, 1'b0, -1);

        // Checkerboard with threshold on equality.
        fill_scores(2);
        run_frame(32'd100, 1'b0, -1);
        if (w_data.size() == NWR) begin
            chk("checker_row2_addr", w_addr[2], 32'd1);
            chk("checker_row2_data", 32'(w_data[2]), 32'h0000_AAA8);
            chk("checker_row1_data", 32'(w_data[0]), 32'h0000_AAAA);
        end

        // Random scores under random backpressure and stray START pulses.
        fill_scores(3);
        run_frame(32'd500, 1'b1, -1);

        // Reset mid-frame, then a clean frame.
        fill_scores(3);
        run_frame(32'd300, 1'b1, 300);
        fill_scores(3);
        run_frame(32'd700, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
